// File: rtl/status_flag_unit.sv
// Condition-flag register {c,n,v,z} with a one-cycle write, same-cycle forward
// path, and a shadow copy for save/restore around exceptions.
module status_flag_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  flag_kind,
    input  logic        s_bit,
    input  logic        valid,
    input  logic        freeze,
    input  logic        flush,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] result,
    input  logic        carry_out,
    input  logic        save,
    input  logic        restore,
    output logic [3:0]  status_register,
    output logic [3:0]  status_next,
    output logic [3:0]  shadow_status,
    output logic        update_done
);

    typedef enum logic [1:0] {
        KIND_LOGIC = 2'b00,
        KIND_ADD   = 2'b01,
        KIND_SUB   = 2'b10,
        KIND_NONE  = 2'b11
    } kind_e;

    typedef struct packed {
        logic c;
        logic n;
        logic v;
        logic z;
    } flags_t;

    kind_e  kind;
    flags_t live;
    flags_t computed;
    logic   commit;
    logic   sign_a;
    logic   sign_b;
    logic   sign_r;

    // Only the sign bits of the operands feed the overflow rule.
    logic   unused_operand_bits;
    assign unused_operand_bits = ^{op_a[30:0], op_b[30:0]};

    assign kind   = kind_e'(flag_kind);
    assign live   = flags_t'(status_register);
    assign sign_a = op_a[31];
    assign sign_b = op_b[31];
    assign sign_r = result[31];

    // Restore owns the flag port for its cycle, so it also blocks the update.
    assign commit = valid & s_bit & ~flush & ~freeze & ~restore & (kind != KIND_NONE);

    always_comb begin
        // NOTE: start from a full default so every path assigns computed and no latch is inferred.
        computed   = live;
        computed.n = sign_r;
        computed.z = (result == 32'd0);
        case (kind)
            KIND_ADD: begin
                computed.c = carry_out;
                computed.v = (sign_a == sign_b) & (sign_r != sign_a);
            end
            KIND_SUB: begin
                computed.c = carry_out;
                computed.v = (sign_a != sign_b) & (sign_r != sign_a);
            end
            default: ;
        endcase
    end

    always_comb begin
        status_next = status_register;
        if (freeze) begin
            status_next = status_register;
        end else if (restore) begin
            status_next = shadow_status;
        end else if (commit) begin
            status_next = computed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_register <= 4'b0000;
            shadow_status   <= 4'b0000;
            update_done     <= 1'b0;
        end else begin
            // NOTE: non-blocking, so shadow captures the pre-edge flags; save+restore becomes a swap.
            status_register <= status_next;
            if (save && !freeze) begin
                shadow_status <= status_register;
            end
            update_done <= commit;
        end
    end

endmodule

// File: doc/status_flag_unit.md
STATUS_FLAG_UNIT -- requirements
Module: status_flag_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 rst_n  input  1  Asynchronous active-low reset.
REQ-004 flag_kind  input  2  Flag rule: 00 logical, 01 add, 10 sub, 11 no-flag op.
REQ-005 s_bit  input  1  Set-flags request for the instruction currently at the port.
REQ-006 valid  input  1  Instruction at the port is real, not a bubble.
REQ-007 freeze  input  1  Pipeline stall; blocks all state writes.
REQ-008 flush  input  1  Cancels the instruction at the port; no flag write.
REQ-009 op_a, op_b  input  32 each  ALU operands.
REQ-010 result  input  32  ALU result.
REQ-011 carry_out  input  1  ALU carry; for sub this is NOT-borrow.
REQ-012 save  input  1  Copy the live flags into the shadow register.
REQ-013 restore  input  1  Load the live flags from the shadow register.
REQ-014 status_register  output  4  Registered flags, packed {c,n,v,z}.
REQ-015 status_next  output  4  Combinational value status_register takes at the next edge, packed {c,n,v,z}.
REQ-016 shadow_status  output  4  Registered shadow flags, packed {c,n,v,z}.
REQ-017 update_done  output  1  Registered pulse, high for one cycle after a committed flag write.

Function
REQ-018 A write SHALL be committed when valid=1, s_bit=1, flush=0, freeze=0, restore=0 and flag_kind!=11.
REQ-019 Flag computation SHALL use these rules, n and z for every kind:
- n = result[31].
- z = (result == 0).
REQ-020 Logical kind (00) SHALL write n and z only; c and v keep their prior values.
REQ-021 Add kind (01) SHALL write all four flags:
- c = carry_out.
- v = (op_a[31]==op_b[31]) & (result[31]!=op_a[31]).
REQ-022 Sub kind (10) SHALL write all four flags:
- c = carry_out.
- v = (op_a[31]!=op_b[31]) & (result[31]!=op_a[31]).
REQ-023 Kind 11, s_bit=0, valid=0 or flush=1 SHALL leave status_register unchanged.
REQ-024 The write latency SHALL be one cycle: flags are computed in cycle t and visible on status_register after edge t+1.
REQ-025 status_next SHALL equal the value status_register will hold after the next edge, so a condition evaluator in cycle t sees the same-cycle update.
REQ-026 Write priority SHALL be:
- freeze: hold all state.
- otherwise restore: status_register <= shadow_status.
- otherwise a committed write.
- otherwise hold.
REQ-027 save with freeze=0 SHALL set shadow_status <= status_register as it was before the edge, even when an update or restore occurs in the same cycle.
REQ-028 save and restore in the same cycle SHALL swap status_register and shadow_status.
REQ-029 update_done SHALL be 1 in the cycle after a committed write (REQ-018) and 0 otherwise, including after a restore.
REQ-030 A frozen cycle SHALL keep update_done at 0; the held instruction commits when freeze drops, if still valid and not flushed.

Reset
REQ-031 rst_n=0 SHALL immediately and asynchronously force status_register=0000, shadow_status=0000 and update_done=0, independent of clk.
REQ-032 Reset asserted mid-operation SHALL discard any pending write.
REQ-033 After rst_n rises, the first rising edge SHALL operate normally.
REQ-034 status_next SHALL follow REQ-025 from the reset values.

Verification
REQ-035 Add overflow:
- Stimulus: kind 01, s_bit=1, valid=1, op_a=7FFFFFFF, op_b=00000001, result=80000000, carry_out=0.
- Required response: status_register=0110 after one edge; update_done=1 in the next cycle.
REQ-036 Sub equal:
- Stimulus: kind 10, op_a=op_b=00000005, result=0, carry_out=1.
- Required response: status_register=1001.
- Then: logical kind, result=80000000.
- Required response: status_register=1100 (c kept, v=0 kept).
REQ-037 Suppression:
- Stimulus: s_bit=0, kind 11, valid=0, or flush=1, each with result=0.
- Required response: status_register unchanged and update_done=0.
- Stimulus: freeze=1 for 3 cycles with a valid add pending.
- Required response: no change; the write commits on the first unfrozen edge.
REQ-038 Save/restore:
- Stimulus: status=1001; save plus a same-cycle update to 0110.
- Required response: shadow=1001, status=0110.
- Stimulus: restore.
- Required response: status=1001.
- Stimulus: save with restore in one cycle.
- Required response: the values swap.
REQ-039 Forward path:
- Stimulus: a committing add.
- Required response: status_next shows the new flags in the same cycle the inputs are applied; status_register shows them one edge later.
REQ-040 Async reset:
- Stimulus: drop rst_n between edges while status=1111 and shadow=1010.
- Required response: both read 0000 before the next edge; a write on the first edge after release takes effect normally.
